// File: rtl/order_tx_scheduler.sv
// order_tx_scheduler
//   Serialises buy/sell order message pairs onto a ready/valid word stream.
//   Each captured pair is sent as the buy side (if enabled) followed by the
//   sell side (if enabled). One further pair can wait in a pending buffer
//   while a message is in flight. Pairs arriving while that buffer is full
//   are discarded and counted.
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_valid                   one-cycle strobe, new pair on i_buy/i_sell_words
//   i_buy_words/i_sell_words  NUM_WORDS packed words, word k at [k*REG_WIDTH +: REG_WIDTH]
//   i_side_en                 bit0 buy enable, bit1 sell enable (latched at capture)
//   i_tready                  downstream ready
//   o_tdata/o_tvalid/o_tlast  stream word, valid, last word of the side
//   o_tuser                   side of the current word (0 buy, 1 sell)
//   o_busy                    message in flight or pending buffer occupied
//   o_drop_count              saturating count of discarded pairs
module order_tx_scheduler #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_WORDS = 9
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  input  logic [NUM_WORDS*REG_WIDTH-1:0] i_buy_words,
  input  logic [NUM_WORDS*REG_WIDTH-1:0] i_sell_words,
  input  logic [1:0]                     i_side_en,
  input  logic                           i_tready,
  output logic [REG_WIDTH-1:0]           o_tdata,
  output logic                           o_tvalid,
  output logic                           o_tlast,
  output logic                           o_tuser,
  output logic                           o_busy,
  output logic [15:0]                    o_drop_count
);

  localparam int MW = NUM_WORDS * REG_WIDTH;
  localparam int BW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, SEND_BUY, SEND_SELL} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [MW-1:0]  act_buy_q, act_buy_d, act_sell_q, act_sell_d;
  logic [1:0]     act_en_q, act_en_d;
  logic           pend_valid_q, pend_valid_d;
  logic [MW-1:0]  pend_buy_q, pend_buy_d, pend_sell_q, pend_sell_d;
  logic [1:0]     pend_en_q, pend_en_d;
  logic [15:0]    drop_q, drop_d;
  logic [REG_WIDTH-1:0] tdata_q, tdata_d;
  logic           tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;

  logic           new_ok, fire, at_last, eom;
  logic [MW-1:0]  side_words;

  // First side to transmit for a given (nonzero) enable pair.
  function automatic state_t first_state(input logic [1:0] en);
    return en[0] ? SEND_BUY : SEND_SELL;
  endfunction

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    act_buy_d    = act_buy_q;
    act_sell_d   = act_sell_q;
    act_en_d     = act_en_q;
    pend_valid_d = pend_valid_q;
    pend_buy_d   = pend_buy_q;
    pend_sell_d  = pend_sell_q;
    pend_en_d    = pend_en_q;
    drop_d       = drop_q;

    // Pairs with no side enabled are ignored outright: never buffered, never counted.
    new_ok  = i_valid && (i_side_en != 2'b00);
    fire    = (state_q != IDLE) && i_tready;
    at_last = (beat_q == LAST_BEAT);
    eom     = fire && at_last && ((state_q == SEND_SELL) || !act_en_q[1]);

    if (state_q == IDLE) begin
      if (new_ok) begin
        act_buy_d  = i_buy_words;
        act_sell_d = i_sell_words;
        act_en_d   = i_side_en;
        beat_d     = '0;
        state_d    = first_state(i_side_en);
      end
    end else if (eom) begin
      beat_d = '0;
      if (pend_valid_q) begin
        // Pending advances to active; a coincident new pair refills pending.
        act_buy_d    = pend_buy_q;
        act_sell_d   = pend_sell_q;
        act_en_d     = pend_en_q;
        state_d      = first_state(pend_en_q);
        pend_valid_d = new_ok;
        if (new_ok) begin
          pend_buy_d  = i_buy_words;
          pend_sell_d = i_sell_words;
          pend_en_d   = i_side_en;
        end
      end else if (new_ok) begin
        act_buy_d  = i_buy_words;
        act_sell_d = i_sell_words;
        act_en_d   = i_side_en;
        state_d    = first_state(i_side_en);
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (fire) begin
        if (at_last) begin
          // Only reachable from the buy side with sell enabled.
          state_d = SEND_SELL;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      if (new_ok) begin
        if (!pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_buy_d   = i_buy_words;
          pend_sell_d  = i_sell_words;
          pend_en_d    = i_side_en;
        end else if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end
    end

    // Outputs are registered from the next-state view, so they stay put
    // whenever the state and beat do (i.e. during stalls).
    side_words = (state_d == SEND_SELL) ? act_sell_d : act_buy_d;
    tvalid_d   = (state_d != IDLE);
    tuser_d    = (state_d == SEND_SELL);
    tlast_d    = tvalid_d && (beat_d == LAST_BEAT);
    tdata_d    = tvalid_d ? side_words[int'(beat_d)*REG_WIDTH +: REG_WIDTH] : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      act_buy_q    <= '0;
      act_sell_q   <= '0;
      act_en_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_buy_q   <= '0;
      pend_sell_q  <= '0;
      pend_en_q    <= '0;
      drop_q       <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      act_buy_q    <= act_buy_d;
      act_sell_q   <= act_sell_d;
      act_en_q     <= act_en_d;
      pend_valid_q <= pend_valid_d;
      pend_buy_q   <= pend_buy_d;
      pend_sell_q  <= pend_sell_d;
      pend_en_q    <= pend_en_d;
      drop_q       <= drop_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
    end
  end

  assign o_tdata      = tdata_q;
  assign o_tvalid     = tvalid_q;
  assign o_tlast      = tlast_q;
  assign o_tuser      = tuser_q;
  assign o_drop_count = drop_q;
  assign o_busy       = (state_q != IDLE) || pend_valid_q;

endmodule

// File: tb/tb_order_tx_scheduler.sv
// Directed bench for order_tx_scheduler: a negedge monitor logs every
// transferred beat (data, side, last, cycle) and directed scenarios compare
// the log against hand-computed word sequences.
module tb_order_tx_scheduler;
  localparam int RW = 32;
  localparam int NW = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic [NW*RW-1:0] buy_words = '0;
  logic [NW*RW-1:0] sell_words = '0;
  logic [1:0]      side_en = 2'b00;
  logic            tready = 1'b1;
  logic [RW-1:0]   tdata;
  logic            tvalid, tlast, tuser, busy;
  logic [15:0]     drop_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [RW-1:0] log_data[$];
  logic          log_user[$];
  logic          log_last[$];
  int            log_cyc[$];
  int            ptr;

  logic          prev_stall = 1'b0;
  logic [33:0]   prev_word = '0;

  order_tx_scheduler #(.REG_WIDTH(RW), .NUM_WORDS(NW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_buy_words(buy_words), .i_sell_words(sell_words),
    .i_side_en(side_en), .i_tready(tready),
    .o_tdata(tdata), .o_tvalid(tvalid), .o_tlast(tlast), .o_tuser(tuser),
    .o_busy(busy), .o_drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Log transfers and check that stalled outputs do not move.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && tvalid) check("stall_hold", {tuser, tlast, tdata}, prev_word);
      if (tvalid && tready) begin
        log_data.push_back(tdata);
        log_user.push_back(tuser);
        log_last.push_back(tlast);
        log_cyc.push_back(cyc);
      end
      prev_stall = tvalid && !tready;
      prev_word  = {tuser, tlast, tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_data.delete(); log_user.delete(); log_last.delete(); log_cyc.delete();
    ptr = 0;
  endtask

  task automatic send(input int bb, input int sb, input logic [1:0] en);
    for (int k = 0; k < NW; k++) begin
      buy_words[k*RW +: RW]  = RW'(bb + k);
      sell_words[k*RW +: RW] = RW'(sb + k);
    end
    side_en = en;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    side_en = 2'b00;
  endtask

  // Compares the next beats in the log with one expected message.
  task automatic expect_msg(input string tag, input int bb, input int sb, input logic [1:0] en);
    for (int s = 0; s < 2; s++) begin
      if (en[s]) begin
        for (int k = 0; k < NW; k++) begin
          if (ptr < log_data.size())
            check($sformatf("%s_s%0d_w%0d", tag, s, k),
                  {log_user[ptr], log_last[ptr], log_data[ptr]},
                  {s[0], (k == NW - 1), RW'((s == 0 ? bb : sb) + k)});
          else
            check($sformatf("%s_missing_s%0d_w%0d", tag, s, k), 0, 1);
          ptr++;
        end
      end
    end
  endtask

  task automatic check_contig(input string tag);
    for (int i = 1; i < log_cyc.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), 64'(log_cyc[i] - log_cyc[i-1]), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check({tag, "_idle_timeout"}, busy, 0);
    tick();
    check({tag, "_tvalid_low"}, tvalid, 0);
  endtask

  initial begin
    int start_cyc;
    int n;
    logic saw_last;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tuser", tuser, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    tick();

    // Both sides, always ready.
    clear_log();
    start_cyc = cyc;
    send(32'h100, 32'h200, 2'b11);
    wait_idle("both");
    check("both_count", log_data.size(), 18);
    if (log_cyc.size() > 0) check("both_latency", 64'(log_cyc[0] - start_cyc), 1);
    expect_msg("both", 32'h100, 32'h200, 2'b11);
    check_contig("both");
    $display("scenario both_sides beats=%0d", log_data.size());

    // Sell only, then nothing enabled.
    clear_log();
    send(32'h100, 32'h200, 2'b10);
    wait_idle("sell");
    check("sell_count", log_data.size(), 9);
    expect_msg("sell", 32'h100, 32'h200, 2'b10);
    clear_log();
    send(32'h100, 32'h200, 2'b00);
    repeat (5) tick();
    check("none_count", log_data.size(), 0);
    check("none_busy", busy, 0);
    check("none_drop", drop_count, 0);
    $display("scenario sell_only_and_none done");

    // Ready toggling each cycle.
    clear_log();
    tready = 1'b1;
    send(32'h100, 32'h200, 2'b11);
    for (int i = 0; i < 60 && busy; i++) begin tready = ~tready; tick(); end
    tready = 1'b1;
    wait_idle("toggle");
    check("toggle_count", log_data.size(), 18);
    expect_msg("toggle", 32'h100, 32'h200, 2'b11);
    $display("scenario ready_toggle beats=%0d", log_data.size());

    // Pending and drop with downstream stalled.
    clear_log();
    tready = 1'b0;
    send(32'h100, 32'h200, 2'b11);
    send(32'h300, 32'h400, 2'b11);
    send(32'h500, 32'h600, 2'b11);
    tick();
    check("drop_count1", drop_count, 1);
    check("drop_busy", busy, 1);
    check("drop_no_beats", log_data.size(), 0);
    tready = 1'b1;
    wait_idle("drop");
    check("drop_total", log_data.size(), 36);
    expect_msg("drop_m1", 32'h100, 32'h200, 2'b11);
    expect_msg("drop_m2", 32'h300, 32'h400, 2'b11);
    check_contig("drop");
    check("drop_count_final", drop_count, 1);
    $display("scenario pending_drop beats=%0d drops=%0d", log_data.size(), drop_count);

    // New pair coincident with the sell last-beat transfer.
    clear_log();
    send(32'h100, 32'h200, 2'b11);
    n = 0;
    while (!(tvalid && tlast && tuser) && n < 50) begin tick(); n++; end
    check("b2b_reach_last", tvalid && tlast && tuser, 1);
    send(32'h700, 32'h800, 2'b01);
    wait_idle("b2b");
    check("b2b_total", log_data.size(), 27);
    expect_msg("b2b_m1", 32'h100, 32'h200, 2'b11);
    expect_msg("b2b_m2", 32'h700, 32'h800, 2'b01);
    check_contig("b2b");
    $display("scenario back_to_back beats=%0d", log_data.size());

    // Reset in the middle of the buy side.
    clear_log();
    send(32'h100, 32'h200, 2'b11);
    n = 0;
    while (!(tvalid && tdata == 32'h104) && n < 50) begin tick(); n++; end
    check("rst_reach_beat4", tdata, 32'h104);
    rst_n = 1'b0;
    for (int k = 0; k < NW; k++) buy_words[k*RW +: RW] = RW'(32'h900 + k);
    side_en = 2'b11;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    side_en = 2'b00;
    rst_n = 1'b1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_tlast", tlast, 0);
    saw_last = 1'b0;
    foreach (log_last[i]) saw_last |= log_last[i];
    check("mid_rst_no_last", saw_last, 0);
    tick();
    check("mid_rst_ignored_valid", busy, 0);
    clear_log();
    send(32'h100, 32'h200, 2'b11);
    wait_idle("after_rst");
    check("after_rst_count", log_data.size(), 18);
    expect_msg("after_rst", 32'h100, 32'h200, 2'b11);
    $display("scenario mid_reset beats=%0d", log_data.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
